// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter/sequencer sharing one LIFO stack between two requesters.
// Stack flags are checked in IDLE, so a rejected request never strobes the stack.
module stack_arbiter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         Req0,
    input  logic         Req1,
    input  logic         Op0,
    input  logic         Op1,
    input  logic [W-1:0] Din0,
    input  logic [W-1:0] Din1,
    output logic         Ack0,
    output logic         Ack1,
    output logic         Err,
    output logic [W-1:0] Dout,
    output logic         Busy,
    output logic         St_push,
    output logic         St_pop,
    output logic [W-1:0] St_Data_In,
    input  logic [W-1:0] St_Data_Out,
    input  logic         St_Full,
    input  logic         St_Empty,
    input  logic         St_Error
);
    // state   | meaning
    // IDLE    | arbitrate between unmasked requests
    // ISSUE   | single-cycle push/pop strobe to the stack
    // CAPTURE | sample popped data and stack error flag
    // RESP    | acknowledge winner, mask it for one cycle
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t       state, state_nxt;
    logic         win, op, last;
    logic [1:0]   mask, eff, mask_d;
    logic         grant, win_nxt, op_nxt, illegal;
    logic [W-1:0] din_nxt, dout_d, st_din_d;
    logic         ack_d, ack_id, err_d, push_d, pop_d, busy_d;

    always_comb begin
        eff       = {Req1, Req0} & ~mask;
        grant     = |eff;
        win_nxt   = (&eff) ? ~last : eff[1];
        op_nxt    = win_nxt ? Op1 : Op0;
        din_nxt   = win_nxt ? Din1 : Din0;
        illegal   = op_nxt ? St_Full : St_Empty;
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = illegal ? RESP : ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // every output is registered, so the d-values describe the next cycle
    always_comb begin
        ack_d    = 1'b0;
        ack_id   = win;
        err_d    = 1'b0;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        st_din_d = '0;
        dout_d   = Dout;
        mask_d   = 2'b00;
        busy_d   = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (grant) begin
                    ack_id = win_nxt;
                    if (illegal) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        push_d   = op_nxt;
                        pop_d    = ~op_nxt;
                        st_din_d = op_nxt ? din_nxt : '0;
                    end
                end
            end
            CAPTURE: begin
                ack_d = 1'b1;
                err_d = St_Error;
                if (!op) dout_d = St_Data_Out;
            end
            RESP:    mask_d = win ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RstN) begin
            state      <= IDLE;
            win        <= 1'b0;
            op         <= 1'b0;
            last       <= 1'b1;
            mask       <= 2'b00;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            Err        <= 1'b0;
            Dout       <= '0;
            Busy       <= 1'b0;
            St_push    <= 1'b0;
            St_pop     <= 1'b0;
            St_Data_In <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant) begin
                win  <= win_nxt;
                op   <= op_nxt;
                last <= win_nxt;
            end
            mask       <= mask_d;
            Ack0       <= ack_d & ~ack_id;
            Ack1       <= ack_d & ack_id;
            Err        <= err_d;
            Dout       <= dout_d;
            Busy       <= busy_d;
            St_push    <= push_d;
            St_pop     <= pop_d;
            St_Data_In <= st_din_d;
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random requester traffic against a stack model,
// checked cycle by cycle against a transaction-level schedule of expected outputs.
module tb_stack_arbiter;
    localparam int W = 4;
    localparam int DEPTH = 4;
    localparam int RING = 16;

    logic         Clk = 1'b0;
    logic         RstN = 1'b1;
    logic [1:0]   req = 2'b00;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] din [2];
    logic         Ack0, Ack1, Err, Busy, St_push, St_pop;
    logic [W-1:0] Dout, St_Data_In, St_Data_Out;
    logic         St_Full, St_Empty, St_Error;

    always #5 Clk = ~Clk;

    stack_arbiter #(.W(W)) dut (
        .Clk(Clk), .RstN(RstN),
        .Req0(req[0]), .Req1(req[1]), .Op0(op[0]), .Op1(op[1]),
        .Din0(din[0]), .Din1(din[1]),
        .Ack0(Ack0), .Ack1(Ack1), .Err(Err), .Dout(Dout), .Busy(Busy),
        .St_push(St_push), .St_pop(St_pop), .St_Data_In(St_Data_In),
        .St_Data_Out(St_Data_Out), .St_Full(St_Full), .St_Empty(St_Empty),
        .St_Error(St_Error)
    );

    // stack the arbiter drives; never reset, like a separate block
    logic [W-1:0] mem [DEPTH];
    int           sp = 0;
    logic         st_err = 1'b0;
    logic [W-1:0] st_q = '0;
    assign St_Full     = (sp == DEPTH);
    assign St_Empty    = (sp == 0);
    assign St_Error    = st_err;
    assign St_Data_Out = st_q;

    always @(posedge Clk) begin
        if (St_push) begin
            if (sp < DEPTH) begin
                mem[sp] <= St_Data_In;
                sp      <= sp + 1;
                st_err  <= 1'b0;
            end else st_err <= 1'b1;
        end else if (St_pop) begin
            if (sp > 0) begin
                st_q   <= mem[sp-1];
                sp     <= sp - 1;
                st_err <= 1'b0;
            end else st_err <= 1'b1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // expected outputs per future cycle
    logic         e_ack0 [RING], e_ack1 [RING], e_err [RING], e_errchk [RING];
    logic         e_push [RING], e_pop [RING], e_busy [RING], e_dset [RING];
    logic [W-1:0] e_din [RING], e_dval [RING];
    logic [W-1:0] exp_dout = '0;

    // reference model: stack contents and arbiter schedule
    logic [W-1:0] q [$];
    int           free_c = 0, mask_c = -1, mask_id = 0;
    logic         last = 1'b1;
    int           grant_c [2] = '{-1, -1};

    // requester drivers: 0 idle, 1 holding Req, 2 dropped early awaiting Ack, 3 cooldown
    int           st [2] = '{0, 0};
    int           wait_n [2], req_start [2];
    int           quota [2] = '{0, 0};
    int           prob [2] = '{0, 0};
    int           opmode [2] = '{0, 0};
    int           early [2] = '{0, 0};
    logic [W-1:0] dnext [2];
    logic         dinc [2], drand [2], drop_req [2];
    logic         scramble = 1'b0;
    logic         rst_next = 1'b1;

    task automatic clear_ring();
        for (int k = 0; k < RING; k++) begin
            e_ack0[k] = 0; e_ack1[k] = 0; e_err[k] = 0; e_errchk[k] = 0;
            e_push[k] = 0; e_pop[k] = 0; e_busy[k] = 0; e_dset[k] = 0;
            e_din[k] = '0; e_dval[k] = '0;
        end
    endtask

    task automatic drive(input int i);
        logic ack;
        ack = (i == 0) ? Ack0 : Ack1;
        case (st[i])
            0: if (quota[i] != 0 && $urandom_range(99) < 32'(prob[i])) begin
                req[i] = 1'b1;
                op[i] = (opmode[i] == 2) ? 1'($urandom_range(1)) : 1'(opmode[i]);
                din[i] = drand[i] ? W'($urandom) : dnext[i];
                if (dinc[i]) dnext[i] = dnext[i] + 1'b1;
                if (quota[i] > 0) quota[i]--;
                drop_req[i] = (early[i] == 1) || (early[i] == 2 && $urandom_range(3) == 0);
                req_start[i] = cyc;
                wait_n[i] = 0;
                st[i] = 1;
            end
            1, 2: begin
                if (ack) begin
                    req[i] = 1'b0;
                    st[i] = 3;
                end else begin
                    if (st[i] == 1 && grant_c[i] == cyc - 1 && grant_c[i] >= req_start[i]) begin
                        if (drop_req[i]) begin
                            req[i] = 1'b0;
                            st[i] = 2;
                        end else if (scramble) begin
                            op[i] = 1'($urandom_range(1));
                            din[i] = W'($urandom);
                        end
                    end
                    wait_n[i]++;
                    if (wait_n[i] > 40) begin
                        chk($sformatf("ack%0d_wait", i), 32'(wait_n[i]), 32'd40);
                        req[i] = 1'b0;
                        st[i] = 0;
                    end
                end
            end
            default: st[i] = 0;
        endcase
    endtask

    task automatic model();
        logic e0, e1, w, o, legal;
        logic [W-1:0] d, v;
        if (RstN) begin
            clear_ring();
            e_dset[(cyc+1)%RING] = 1'b1;
            e_dval[(cyc+1)%RING] = '0;
            e_errchk[(cyc+1)%RING] = 1'b1;
            free_c = cyc + 1;
            mask_c = -1;
            last = 1'b1;
            for (int i = 0; i < 2; i++) begin
                wait_n[i] = 0;
                if (st[i] == 2) st[i] = 0;
            end
        end else if (cyc >= free_c) begin
            e0 = req[0] && !(mask_c == cyc && mask_id == 0);
            e1 = req[1] && !(mask_c == cyc && mask_id == 1);
            if (e0 || e1) begin
                w = (e0 && e1) ? !last : e1;
                last = w;
                grant_c[w] = cyc;
                o = op[w];
                d = din[w];
                legal = o ? (q.size() < DEPTH) : (q.size() > 0);
                if (legal) begin
                    if (o) begin
                        q.push_back(d);
                        e_push[(cyc+1)%RING] = 1'b1;
                        e_din[(cyc+1)%RING] = d;
                    end else begin
                        v = q.pop_back();
                        e_pop[(cyc+1)%RING] = 1'b1;
                        e_dset[(cyc+3)%RING] = 1'b1;
                        e_dval[(cyc+3)%RING] = v;
                    end
                    for (int k = 1; k <= 3; k++) e_busy[(cyc+k)%RING] = 1'b1;
                    if (w) e_ack1[(cyc+3)%RING] = 1'b1; else e_ack0[(cyc+3)%RING] = 1'b1;
                    e_errchk[(cyc+3)%RING] = 1'b1;
                    free_c = cyc + 4;
                end else begin
                    e_busy[(cyc+1)%RING] = 1'b1;
                    if (w) e_ack1[(cyc+1)%RING] = 1'b1; else e_ack0[(cyc+1)%RING] = 1'b1;
                    e_err[(cyc+1)%RING] = 1'b1;
                    e_errchk[(cyc+1)%RING] = 1'b1;
                    free_c = cyc + 2;
                end
                mask_c = free_c;
                mask_id = int'(w);
            end
        end
    endtask

    task automatic step();
        int k;
        @(negedge Clk);
        k = cyc % RING;
        chk("ack0", Ack0, e_ack0[k]);
        chk("ack1", Ack1, e_ack1[k]);
        if (e_errchk[k]) chk("err", Err, e_err[k]);
        chk("st_push", St_push, e_push[k]);
        chk("st_pop", St_pop, e_pop[k]);
        chk("st_data_in", St_Data_In, e_din[k]);
        chk("busy", Busy, e_busy[k]);
        if (e_dset[k]) exp_dout = e_dval[k];
        chk("dout", Dout, exp_dout);
        e_ack0[k] = 0; e_ack1[k] = 0; e_err[k] = 0; e_errchk[k] = 0;
        e_push[k] = 0; e_pop[k] = 0; e_busy[k] = 0; e_dset[k] = 0; e_din[k] = '0;
        RstN = rst_next;
        drive(0);
        drive(1);
        model();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic set_req(input int i, input int qn, input int om, input logic [W-1:0] d0,
                           input logic inc, input int pr, input int ed);
        quota[i] = qn; opmode[i] = om; dnext[i] = d0; dinc[i] = inc;
        drand[i] = 1'b0; prob[i] = pr; early[i] = ed;
    endtask

    initial begin
        int t, g0;
        din[0] = '0; din[1] = '0;
        clear_ring();
        // reset, then requester 0 pushes 1,2,3
        rst_next = 1'b1;
        run(2);
        rst_next = 1'b0;
        set_req(0, 3, 1, 4'd1, 1'b1, 100, 0);
        run(20);
        // requester 1 pops four times; last pop hits the empty stack
        set_req(1, 4, 0, 4'd0, 1'b0, 100, 0);
        run(20);
        // both hold requests from reset, pushing 5 and 9 until the stack is full
        set_req(0, 2, 1, 4'd5, 1'b0, 100, 0);
        set_req(1, 2, 1, 4'd9, 1'b0, 100, 0);
        rst_next = 1'b1;
        run(1);
        rst_next = 1'b0;
        run(25);
        // push on a full stack, then pop the last pushed value
        set_req(0, 1, 1, 4'd15, 1'b0, 100, 0);
        run(8);
        set_req(1, 1, 0, 4'd0, 1'b0, 100, 0);
        run(10);
        // reset during CAPTURE, then a tie that requester 0 must win
        set_req(0, 1, 1, 4'd7, 1'b0, 100, 0);
        g0 = grant_c[0];
        t = 0;
        while (grant_c[0] == g0 && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) chk("grant_wait", 32'(t), 32'd0);
        step();
        rst_next = 1'b1;
        set_req(1, 1, 1, 4'd3, 1'b0, 100, 0);
        run(1);
        rst_next = 1'b0;
        run(15);
        // requester drops Req in the ISSUE cycle
        set_req(0, 2, 2, 4'd11, 1'b1, 100, 1);
        run(20);
        // random traffic with occasional resets
        for (int i = 0; i < 2; i++) begin
            quota[i] = -1; opmode[i] = 2; drand[i] = 1'b1; dinc[i] = 1'b0;
            prob[i] = 45; early[i] = 2;
        end
        scramble = 1'b1;
        for (int j = 0; j < 800; j++) begin
            rst_next = ($urandom_range(149) == 0);
            step();
        end
        rst_next = 1'b0;
        quota[0] = 0;
        quota[1] = 0;
        run(50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-port round-robin arbiter and sequencer that shares one `stack` instance (push/pop LIFO with `Full`/`Empty`/`Error` flags) between two independent requesters.
- Each requester posts a push or pop request and holds it until acknowledged.
- The block pre-checks stack flags, issues exactly one single-cycle `push` or `pop` strobe per granted request, captures popped data and returns an acknowledge with error status.
- It is the only driver of the stack's `push`/`pop`/`Data_In` pins.

## Interface
Parameters:
- `W`, default 4: data width; must equal the stack data width.

Ports (all outputs registered):
- `Clk` in 1: clock, rising-edge.
- `RstN` in 1: reset. Synchronous, active-high; sampled on `Clk` rising edge.
- `Req0`, `Req1` in 1: request from requester 0/1, held high until the matching `Ack` is seen.
- `Op0`, `Op1` in 1: operation, 1 = push, 0 = pop; stable while `Req` is high.
- `Din0`, `Din1` in W: push data; stable while `Req` is high.
- `Ack0`, `Ack1` out 1: one-cycle completion pulse to requester 0/1.
- `Err` out 1: valid when either `Ack` is high; 1 = request rejected or failed.
- `Dout` out W: popped data; valid when `Ack` is high for a successful pop, otherwise holds its previous value.
- `Busy` out 1: high in every state except `IDLE`.
- `St_push`, `St_pop` out 1: strobes to the stack; never both high.
- `St_Data_In` out W: data to the stack.
- `St_Data_Out` in W: stack read data; valid the cycle after `pop` is sampled.
- `St_Full`, `St_Empty`, `St_Error` in 1: stack flags; these reflect state after the last edge.

## Operation
FSM has four states: `IDLE`, `ISSUE`, `CAPTURE`, `RESP`.

`IDLE`:
- Effective requests are `Req` AND NOT `Mask`.
- If none, stay in `IDLE`.
- If one, grant it.
- If both, grant the requester not equal to `Last`.
- On grant, latch winner, op and data. `Last` ← winner.
- Illegal request (push with `St_Full`=1, or pop with `St_Empty`=1): go to `RESP` with pending `Err`=1. No stack strobe is issued.
- Legal request: go to `ISSUE`.

`ISSUE`:
- Drive `St_push`=1 or `St_pop`=1 for exactly this cycle.
- `St_Data_In` = latched data on a push, otherwise 0.
- Go to `CAPTURE`.

`CAPTURE`:
- On a pop, `Dout` ← `St_Data_Out`.
- Pending `Err` ← `St_Error`.
- Go to `RESP`. Pushes also pass through this state so legal latency is uniform.

`RESP`:
- Drive the winner's `Ack` high with `Err`.
- `Mask` ← one-hot of the winner for exactly the next cycle; this absorbs the requester dropping `Req`.
- Go to `IDLE`.

Rules:
- A requester must deassert `Req` by the cycle after its `Ack`. It may reassert `Req` one cycle after that.
- A granted operation completes even if `Req` drops early.
- `Op`/`Din` changes after grant are ignored.
- Fairness: when both requesters are continuously pending, grants alternate 0,1,0,1…

## Timing
Reset:
- Values: state `IDLE`, `Ack0`=`Ack1`=0, `Err`=0, `Dout`=0, `Busy`=0, `St_push`=`St_pop`=0, `St_Data_In`=0, `Mask`=0, `Last`=1 (requester 0 wins the first tie).
- Reset mid-operation aborts the transaction without an `Ack`. A strobe already sampled by the stack is not undone.

Latency, counted from the `IDLE` cycle in which `Req` is sampled (cycle 0):
- Legal request: strobe in cycle 1, capture in cycle 2, `Ack` in cycle 3.
- Illegal request: `Ack` with `Err`=1 in cycle 1.

Throughput:
- Minimum spacing between strobes is 4 cycles.
- With both requesters pending back-to-back, the second grant occurs in the `IDLE` cycle right after `RESP`. `Mask` blocks only the just-served requester.

## Test plan
- Reset, then requester 0 pushes 1,2,3 sequentially, each pushed value held until `Ack0` → one `St_push` pulse per request, `St_Data_In`=1,2,3, `Ack0` in cycle 3 each time, `Err`=0.
- Requester 1 pops three times → `Dout`=3,2,1 with `Ack1`, `Err`=0; a fourth pop on the empty stack → `Ack1` in cycle 1, `Err`=1, no `St_pop`, `Dout` stays 1.
- Both requesters hold `Req` continuously from reset, pushing 5 and 9 → grant order 0,1,0,1; `Ack0`/`Ack1` alternate; no cycle has both `Ack`s or both strobes high.
- Fill the stack to `St_Full`=1, then push 15 → `Err`=1, no `St_push`; a following pop → `Dout` = last pushed value, `Err`=0.
- Assert `RstN` during `CAPTURE` → next cycle all outputs are at reset values, no `Ack`; the next tie is granted to requester 0.
- Requester drops `Req` in the `ISSUE` cycle → operation still completes and `Ack` is pulsed once; no second grant to that requester.
